dmem_latency_responder: RTL and testbench

//  Responder end of the pipeline's data-memory port: services the read/write request the MW stage

---
 rtl/dmem_latency_responder_if.sv | 23 ++
 rtl/dmem_latency_responder.sv | 138 +++++++++++++
 tb/tb_dmem_latency_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_latency_responder_if.sv
// Data-memory port bundle between the MW stage (master) and the latency responder (slave).
interface dmem_latency_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [15:0] stat_reads;
    logic [15:0] stat_writes;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, stall, done, err, stat_reads, stat_writes
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, stall, done, err, stat_reads, stat_writes
    );
endinterface

// File: rtl/dmem_latency_responder.sv
// Data-memory responder with programmable access latency, pipeline stall and sticky error flag.
// Optional completed-access counters are built when DMEM_STATS_EN is defined.
module dmem_latency_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 3,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input logic                     clk,
    input logic                     reset,
    dmem_latency_responder_if.slave bus
);
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam logic [32:0] WIN_BYTES = 33'(4) << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic                 req;
    logic                 direct;
    logic                 go_resp;
    logic [31:0]          acc_addr;
    logic [31:0]          acc_wdata;
    logic                 acc_rd;
    logic                 acc_wr;
    logic [31:0]          off;
    logic                 in_win;
    logic                 illegal;
    logic [ADDR_BITS-1:0] idx;
    logic                 mem_we;

    // With LATENCY==1 the access happens on the accept edge, so it uses the live request.
    always_comb begin
        req       = bus.mem_read | bus.mem_write;
        direct    = (state_q == IDLE) && req && (LATENCY == 1);
        go_resp   = direct || ((state_q == WAIT) && (cnt_q == 4'd1));
        acc_addr  = direct ? bus.addr      : addr_q;
        acc_wdata = direct ? bus.wdata     : wdata_q;
        acc_rd    = direct ? bus.mem_read  : rd_q;
        acc_wr    = direct ? bus.mem_write : wr_q;
        off       = acc_addr - BASE_ADDR;
        in_win    = {1'b0, off} < WIN_BYTES;
        illegal   = !in_win || (acc_addr[1:0] != 2'b00) || (acc_rd && acc_wr);
        idx       = off[ADDR_BITS+1:2];
        mem_we    = go_resp && acc_wr && in_win && !reset;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (go_resp) begin
                done_q <= 1'b1;
                if (illegal) begin
                    err_q <= 1'b1;
                end
                if (acc_rd) begin
                    rdata_q <= (in_win && !acc_wr) ? mem[idx] : '0;
                end
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        rd_q    <= bus.mem_read;
                        wr_q    <= bus.mem_write;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall = (state_q == WAIT) || ((state_q == IDLE) && req);
    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (go_resp && !illegal) begin
            if (acc_rd && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (acc_wr && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign bus.stat_reads  = rd_cnt_q;
    assign bus.stat_writes = wr_cnt_q;
`else
    assign bus.stat_reads  = '0;
    assign bus.stat_writes = '0;
`endif
endmodule

// File: tb/tb_dmem_latency_responder.sv
// Scoreboard bench for dmem_latency_responder: stimulus queues expected responses, a monitor checks each done.
module tb_dmem_latency_responder;
    localparam int LAT = 3;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
        logic        chk;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic err_model = 1'b0;
    exp_t q[$];

    dmem_latency_responder_if bus();

    dmem_latency_responder #(
        .ADDR_BITS(10),
        .LATENCY  (LAT),
        .BASE_ADDR(32'h1000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request at posedge+#1, hold it through RESP, return in the following IDLE cycle.
    task automatic access(input string nm, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic ill);
        exp_t e;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        err_model     = err_model | ill;
        e.cyc = cyc + LAT;
        e.rd  = exp_rd;
        e.err = err_model;
        e.chk = rd;
        e.nm  = nm;
        q.push_back(e);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk({nm, " stall"}, {31'b0, bus.stall}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({nm, " resp stall"}, {31'b0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic reset_pulse();
        reset     = 1'b1;
        err_model = 1'b0;
        @(negedge clk);
        chk("rst done", {31'b0, bus.done}, 32'd0);
        chk("rst err", {31'b0, bus.err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious done: got done=1 at cycle %0d expected no response", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.nm, " done cycle"}, cyc, e.cyc);
                chk({e.nm, " err"}, {31'b0, bus.err}, {31'b0, e.err});
                if (e.chk) chk({e.nm, " rdata"}, bus.rdata, e.rd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rdata", bus.rdata, 32'h0);
        chk("reset done", {31'b0, bus.done}, 32'd0);
        chk("reset err", {31'b0, bus.err}, 32'd0);
        chk("reset stall", {31'b0, bus.stall}, 32'd0);
        chk("reset stat_reads", {16'b0, bus.stat_reads}, 32'd0);
        chk("reset stat_writes", {16'b0, bus.stat_writes}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // T1: write then read back
        access("T1 wr", 1'b0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access("T1 rd", 1'b1, 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        // T2: back-to-back reads, request held through RESP
        access("T2 rd0", 1'b1, 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access("T2 rd1", 1'b1, 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access("pre wr20", 1'b0, 1'b1, 32'h1000_0020, 32'h1111_1111, 32'h0, 1'b0);
        access("pre wr00", 1'b0, 1'b1, 32'h1000_0000, 32'h0000_CAFE, 32'h0, 1'b0);
        access("pre rd20", 1'b1, 1'b0, 32'h1000_0020, 32'h0, 32'h1111_1111, 1'b0);
        // T3: out of window read and write; error is sticky
        access("T3 rd oow", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b1);
        access("T3 wr oow", 1'b0, 1'b1, 32'h1000_1000, 32'h0000_0BAD, 32'h0, 1'b1);
        access("T3 rd w0", 1'b1, 1'b0, 32'h1000_0000, 32'h0, 32'h0000_CAFE, 1'b0);
        access("misaligned rd", 1'b1, 1'b0, 32'h1000_0013, 32'h0, 32'hDEAD_BEEF, 1'b1);
        // T4: simultaneous read and write
        access("T4 rdwr", 1'b1, 1'b1, 32'h1000_0004, 32'h5, 32'h0, 1'b1);
        access("T4 rd", 1'b1, 1'b0, 32'h1000_0004, 32'h0, 32'h5, 1'b0);

        // T5: reset during WAIT of a write
        reset_pulse();
        bus.mem_write = 1'b1;
        bus.addr      = 32'h1000_0020;
        bus.wdata     = 32'h0000_0077;
        @(negedge clk);
        chk("T5 stall accept", {31'b0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.mem_write = 1'b0;
        @(negedge clk);
        chk("T5 stall in reset", {31'b0, bus.stall}, 32'd0);
        chk("T5 done in reset", {31'b0, bus.done}, 32'd0);
        chk("T5 rdata in reset", bus.rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("T5 no done", {31'b0, bus.done}, 32'd0);
        end
        @(posedge clk); #1;
        access("T5 rd", 1'b1, 1'b0, 32'h1000_0020, 32'h0, 32'h1111_1111, 1'b0);

        // T6: statistics
        reset_pulse();
        access("T6 wr0", 1'b0, 1'b1, 32'h1000_0030, 32'h1, 32'h0, 1'b0);
        access("T6 wr1", 1'b0, 1'b1, 32'h1000_0034, 32'h2, 32'h0, 1'b0);
        access("T6 wr2", 1'b0, 1'b1, 32'h1000_0038, 32'h3, 32'h0, 1'b0);
        access("T6 rd0", 1'b1, 1'b0, 32'h1000_0030, 32'h0, 32'h1, 1'b0);
        access("T6 rd1", 1'b1, 1'b0, 32'h1000_0038, 32'h0, 32'h3, 1'b0);
        access("T6 ill", 1'b1, 1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
`ifdef DMEM_STATS_EN
        chk("T6 stat_writes", {16'b0, bus.stat_writes}, 32'd3);
        chk("T6 stat_reads", {16'b0, bus.stat_reads}, 32'd2);
`else
        chk("T6 stat_writes", {16'b0, bus.stat_writes}, 32'd0);
        chk("T6 stat_reads", {16'b0, bus.stat_reads}, 32'd0);
`endif
        chk("sticky err", {31'b0, bus.err}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pending responses", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
